instruction_fetch: RTL and testbench
====================================

Name: instruction_fetch

Overview:
- Fetch stage directly upstream of decode and the immediate generator.
- Holds the PC and issues word fetches to instruction memory over a req/ack handshake.
- Captures each returned word into an IF/ID output register of inst, inst_pc and inst_pc_plus4, which feeds decode.
- Supports decode back-pressure (stall) and branch/jump redirect with wrong-path squash.

Parameters:
RESET_PC, 32'h0000_0000, PC loaded on reset; bits [1:0] must be 0
NOP_INST, 32'h0000_0013, bubble word (addi x0,x0,0) driven on inst when invalid

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  reset, asynchronous, active-high
imem_req  output  1  fetch request
imem_addr  output  32  word address of request, bits [1:0] always 0
imem_ack  input  1  memory response valid this cycle; same-cycle ack allowed
imem_rdata  input  32  instruction word, valid when imem_ack=1
stall  input  1  decode cannot accept; hold output register
redirect_valid  input  1  branch/jump taken; flush and refetch
redirect_pc  input  32  redirect target; bits [1:0] ignored (forced 0)
inst_valid  output  1  output register holds a live instruction
inst  output  32  instruction to decode / immediate generator
inst_pc  output  32  PC of inst
inst_pc_plus4  output  32  inst_pc+4 (mod 2^32), for JAL/JALR link

Behaviour:
- Reset (async, immediate): state=S_IDLE, pc=RESET_PC, skid empty, pending=0, inst_valid=0, inst=NOP_INST, inst_pc=0, inst_pc_plus4=0. imem_req=0 during and immediately after reset.
- The output register accepts a word when !inst_valid || !stall. It is written only on an edge; all outputs are registered except imem_req and imem_addr, which decode from state.
- Handshake rule: once imem_req=1, imem_req and imem_addr stay constant until the cycle imem_ack=1. At most one request is outstanding.
- S_IDLE:
  - req=0.
  - Next edge goes to S_FETCH; a redirect arriving here loads pc first.
- S_FETCH:
  - req=1, addr=pc.
  - ack && redirect_valid: discard word, pc<=redirect_pc, stay.
  - ack && accept: output<={imem_rdata, pc, pc+4}, inst_valid<=1, pc<=pc+4, stay. Throughput is 1 instr/cycle with a zero-wait memory.
  - ack && !accept: skid<={imem_rdata, pc}, pc<=pc+4, go S_HOLD.
  - !ack && redirect_valid: pending<=redirect_pc, go S_DROP.
  - !ack, no redirect: stay, holding the request.
- S_HOLD:
  - req=0.
  - redirect_valid: clear skid, pc<=redirect_pc, go S_FETCH.
  - !stall: output<=skid, inst_valid<=1, go S_FETCH.
- S_DROP:
  - req=1 with the old addr (handshake rule).
  - A new redirect_valid overwrites pending.
  - On ack: discard word, pc<=pending (or the same-cycle redirect_pc if redirect_valid), go S_FETCH.
- Redirect flush:
  - Any cycle with redirect_valid=1 sets inst_valid<=0 and inst<=NOP_INST on the next edge, regardless of stall.
  - Redirect has priority over stall and over ack capture.
- Redirect latency with a zero-wait memory: redirect seen in cycle N, target requested in N+1, target on inst_valid in N+2.
- Stall with inst_valid=1: inst, inst_pc and inst_pc_plus4 stay bit-stable.
- Arithmetic: pc+4 wraps from 32'hFFFF_FFFC to 32'h0000_0000; the same applies to inst_pc_plus4.
- Reset mid-request: req drops immediately. Any ack arriving during rst, or in the S_IDLE cycle after it, is ignored.

Decomposition:
- Shared constants file (existing opcode constants file): add NOP_INST and RESET_PC defaults, plus fetch state encodings S_IDLE, S_FETCH, S_HOLD, S_DROP (2-bit).
- One sub-module, program_counter: 32-bit PC register with async reset to RESET_PC and three load controls: incr, load target, hold.

Test Plan:
- Reset release, zero-wait memory returning addr as data → imem_addr 0,4,8 on consecutive cycles; inst_valid first high 2 cycles after rst falls; inst_pc_plus4 = inst_pc+4.
- stall=1 for 3 cycles while inst_valid=1 at pc 0x8, ack still high → inst holds 0x8 word; one fetch of 0xC enters the skid; req=0 in S_HOLD; after stall drops, outputs 0xC and then fetches 0x10, with no loss or duplicate.
- Zero-wait memory, redirect_valid=1 with redirect_pc=0x103 at the 0x10 fetch → next cycle inst_valid=0 and inst=0x00000013; imem_addr=0x100; 0x100 word valid 2 cycles after the redirect.
- 3-cycle memory latency, redirect to 0x200 one cycle into the 0x40 request → req and addr 0x40 held until ack, 0x40 word discarded, next req addr 0x200.
- redirect_valid and stall both high with inst_valid=1 → flush wins; inst_valid=0 next cycle.
- RESET_PC=32'hFFFF_FFF8 → fetches 0xFFFFFFF8, 0xFFFFFFFC, 0x0; inst_pc_plus4 for 0xFFFFFFFC is 0x0. Assert rst mid-request → req low immediately; ack during rst ignored.

Source files
------------

// File: rtl/instruction_fetch_pkg.sv
// Shared constants for the front end: opcode encodings, fetch defaults and fetch-state encodings.
// Also holds the IF/ID and skid payload structs.
package instruction_fetch_pkg;

    localparam int unsigned XLEN = 32;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;

    localparam logic [XLEN-1:0] NOP_INST_DEFAULT = 32'h0000_0013;
    localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_HOLD  = 2'd2,
        S_DROP  = 2'd3
    } fetch_state_e;

    typedef struct packed {
        logic [XLEN-1:0] inst;
        logic [XLEN-1:0] pc;
    } skid_t;

    typedef struct packed {
        logic [XLEN-1:0] inst;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] pc_plus4;
    } ifid_t;

    function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
        return {addr[XLEN-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/instruction_fetch_program_counter.sv
// Fetch PC register: async reset to RESET_PC, then hold, load target or increment by one word.
module program_counter
    import instruction_fetch_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            hold,
    input  logic            load,
    input  logic            incr,
    input  logic [XLEN-1:0] target,
    output logic [XLEN-1:0] pc
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc <= RESET_PC;
        end else if (hold) begin
            pc <= pc;
        end else if (load) begin
            pc <= word_align(target);
        end else if (incr) begin
            pc <= pc + XLEN'(4);
        end
    end

endmodule

// File: rtl/instruction_fetch.sv
// Fetch stage: drives the imem req/ack handshake from the PC and fills the IF/ID register for decode.
// A one-entry skid absorbs the word that returns while decode stalls; S_DROP retires a wrong-path request.
module instruction_fetch
    import instruction_fetch_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT,
    parameter logic [XLEN-1:0] NOP_INST = NOP_INST_DEFAULT
) (
    input  logic            clk,
    input  logic            rst,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_ack,
    input  logic [XLEN-1:0] imem_rdata,
    input  logic            stall,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            inst_valid,
    output logic [XLEN-1:0] inst,
    output logic [XLEN-1:0] inst_pc,
    output logic [XLEN-1:0] inst_pc_plus4
);

    fetch_state_e    state, state_next;
    logic [XLEN-1:0] pc, pc_target, redir_aligned;
    logic [XLEN-1:0] pending, pending_next;
    logic            pc_incr, pc_load, pc_hold, accept;
    skid_t           skid, skid_next;
    ifid_t           out_q, out_next;
    logic            valid_q, valid_next;

    program_counter #(.RESET_PC(RESET_PC)) u_pc (
        .clk    (clk),
        .rst    (rst),
        .hold   (pc_hold),
        .load   (pc_load),
        .incr   (pc_incr),
        .target (pc_target),
        .pc     (pc)
    );

    assign pc_hold       = ~(pc_load | pc_incr);
    assign redir_aligned = word_align(redirect_pc);
    assign accept        = ~valid_q | ~stall;

    // Request lines decode straight from state so they hold steady until ack.
    assign imem_req  = (state == S_FETCH) || (state == S_DROP);
    assign imem_addr = pc;

    assign inst_valid    = valid_q;
    assign inst          = out_q.inst;
    assign inst_pc       = out_q.pc;
    assign inst_pc_plus4 = out_q.pc_plus4;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= S_IDLE;
            pending <= '0;
            skid    <= '0;
            out_q   <= '{inst: NOP_INST, pc: '0, pc_plus4: '0};
            valid_q <= 1'b0;
        end else begin
            state   <= state_next;
            pending <= pending_next;
            skid    <= skid_next;
            out_q   <= out_next;
            valid_q <= valid_next;
        end
    end

    always_comb begin
        state_next   = state;
        pc_incr      = 1'b0;
        pc_load      = 1'b0;
        pc_target    = redir_aligned;
        pending_next = pending;
        skid_next    = skid;
        out_next     = out_q;
        valid_next   = valid_q;

        // Decode took the current word (or there was none); bubble unless refilled below.
        if (accept) begin
            valid_next    = 1'b0;
            out_next.inst = NOP_INST;
        end

        case (state)
            S_IDLE: begin
                state_next = S_FETCH;
                pc_load    = redirect_valid;
            end
            S_FETCH: begin
                if (imem_ack) begin
                    if (redirect_valid) begin
                        pc_load = 1'b1;
                    end else if (accept) begin
                        out_next   = '{inst: imem_rdata, pc: pc, pc_plus4: pc + XLEN'(4)};
                        valid_next = 1'b1;
                        pc_incr    = 1'b1;
                    end else begin
                        skid_next  = '{inst: imem_rdata, pc: pc};
                        pc_incr    = 1'b1;
                        state_next = S_HOLD;
                    end
                end else if (redirect_valid) begin
                    pending_next = redir_aligned;
                    state_next   = S_DROP;
                end
            end
            S_HOLD: begin
                if (redirect_valid) begin
                    pc_load    = 1'b1;
                    skid_next  = '0;
                    state_next = S_FETCH;
                end else if (!stall) begin
                    out_next   = '{inst: skid.inst, pc: skid.pc, pc_plus4: skid.pc + XLEN'(4)};
                    valid_next = 1'b1;
                    state_next = S_FETCH;
                end
            end
            S_DROP: begin
                if (redirect_valid) begin
                    pending_next = redir_aligned;
                end
                if (imem_ack) begin
                    pc_load    = 1'b1;
                    pc_target  = redirect_valid ? redir_aligned : pending;
                    state_next = S_FETCH;
                end
            end
            default: state_next = S_IDLE;
        endcase

        // Redirect squashes whatever decode would see next, stall or not.
        if (redirect_valid) begin
            valid_next    = 1'b0;
            out_next.inst = NOP_INST;
        end
    end

endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: directed scenarios plus random stall/redirect/latency traffic.
// Expected program-order stream is queued by the stimulus side and consumed by an independent monitor.
module tb_instruction_fetch;

    localparam int unsigned HALF = 5;
    localparam logic [31:0] NOP  = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req, imem_ack, stall, redirect_valid;
    logic [31:0] imem_addr, imem_rdata, redirect_pc;
    logic        inst_valid;
    logic [31:0] inst, inst_pc, inst_pc_plus4;

    logic        req2, ack2, valid2;
    logic [31:0] addr2, rdata2, inst2, ipc2, ipc4_2;

    int          total = 0;
    int          bad = 0;
    int          consumed = 0;
    logic [31:0] exp_q[$];
    logic [31:0] last_pushed;
    int unsigned fixed_lat = 0;
    bit          rand_lat = 1'b0;

    always #HALF clk = ~clk;

    function automatic logic [31:0] word_of(input logic [31:0] a);
        return {a[7:0], a[31:8]} ^ 32'h9E37_79B9;
    endfunction

    assign ack2   = 1'b1;
    assign rdata2 = word_of(addr2);

    instruction_fetch #(.RESET_PC(32'h0000_0000)) dut (
        .clk(clk), .rst(rst), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata), .stall(stall),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .inst_valid(inst_valid), .inst(inst), .inst_pc(inst_pc), .inst_pc_plus4(inst_pc_plus4)
    );

    instruction_fetch #(.RESET_PC(32'hFFFF_FFF8)) dut2 (
        .clk(clk), .rst(rst), .imem_req(req2), .imem_addr(addr2),
        .imem_ack(ack2), .imem_rdata(rdata2), .stall(1'b0),
        .redirect_valid(1'b0), .redirect_pc(32'h0),
        .inst_valid(valid2), .inst(inst2), .inst_pc(ipc2), .inst_pc_plus4(ipc4_2)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic refill();
        while (exp_q.size() < 32) begin
            last_pushed = last_pushed + 32'd4;
            exp_q.push_back(last_pushed);
        end
    endtask

    task automatic restart_stream(input logic [31:0] start);
        exp_q.delete();
        last_pushed = {start[31:2], 2'b00};
        exp_q.push_back(last_pushed);
        refill();
    endtask

    task automatic do_redirect(input logic [31:0] target);
        redirect_valid = 1'b1;
        redirect_pc    = target;
        restart_stream(target);
    endtask

    task automatic tick();
        @(negedge clk);
        refill();
    endtask

    task automatic settle();
        #(HALF - 1);
    endtask

    // Memory model: per-request latency, junk acks during reset and in the cycle after release.
    initial begin
        int unsigned cnt, lat;
        logic        prev_rst, req_seen;
        cnt = 0; lat = 0; prev_rst = 1'b1;
        imem_ack = 1'b0; imem_rdata = '0;
        forever begin
            @(negedge clk);
            req_seen = imem_req;
            if (rst || prev_rst) begin
                imem_ack   = 1'b1;
                imem_rdata = 32'hDEAD_BEEF;
            end else begin
                if (imem_req && cnt == 0)
                    lat = rand_lat ? $urandom_range(0, 3) : fixed_lat;
                if (imem_req && cnt >= lat) begin
                    imem_ack   = 1'b1;
                    imem_rdata = word_of(imem_addr);
                end else begin
                    imem_ack   = 1'b0;
                    imem_rdata = $urandom;
                end
            end
            prev_rst = rst;
            @(posedge clk);
            if (rst || !req_seen || imem_ack) cnt = 0;
            else cnt++;
        end
    end

    // Monitor: protocol checks and in-order delivery against the expected stream.
    initial begin
        logic        p_req, p_ack, p_valid, p_stall, p_redir;
        logic [31:0] p_addr, p_inst, p_pc, p_pc4, e;
        bit          have;
        have = 1'b0;
        forever begin
            @(negedge clk);
            settle();
            if (rst) begin
                have = 1'b0;
                continue;
            end
            chk("addr_align", {30'd0, imem_addr[1:0]}, 32'd0);
            if (have && p_req && !p_ack) begin
                chk("req_held", 32'(imem_req), 32'd1);
                chk("addr_held", imem_addr, p_addr);
            end
            if (have && p_valid && p_stall && !p_redir) begin
                chk("stall_inst", inst, p_inst);
                chk("stall_pc", inst_pc, p_pc);
                chk("stall_pc4", inst_pc_plus4, p_pc4);
            end
            if (!inst_valid) chk("bubble", inst, NOP);
            if (inst_valid && !stall && !redirect_valid) begin
                if (exp_q.size() == 0) begin
                    total++; bad++;
                    $display("FAIL stream: delivered pc %h with no expectation queued", inst_pc);
                end else begin
                    e = exp_q.pop_front();
                    chk("stream_pc", inst_pc, e);
                    chk("stream_inst", inst, word_of(e));
                    chk("stream_pc4", inst_pc_plus4, e + 32'd4);
                    consumed++;
                end
            end
            p_req = imem_req; p_ack = imem_ack; p_addr = imem_addr;
            p_valid = inst_valid; p_stall = stall; p_redir = redirect_valid;
            p_inst = inst; p_pc = inst_pc; p_pc4 = inst_pc_plus4;
            have = 1'b1;
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: time limit reached, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    initial begin
        bit got;
        rst = 1'b1; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
        restart_stream(32'h0);

        repeat (3) @(negedge clk);
        settle();
        chk("rst_req", 32'(imem_req), 32'd0);
        chk("rst_valid", 32'(inst_valid), 32'd0);
        chk("rst_inst", inst, NOP);
        chk("rst_pc", inst_pc, 32'd0);
        chk("rst_pc4", inst_pc_plus4, 32'd0);
        chk("rst_req2", 32'(req2), 32'd0);
        chk("rst_inst2", inst2, NOP);

        @(posedge clk); #2; rst = 1'b0;
        tick(); settle();
        chk("idle_req", 32'(imem_req), 32'd0);
        chk("idle_req2", 32'(req2), 32'd0);
        tick(); settle();
        chk("f0_addr", imem_addr, 32'h0);
        chk("f0_valid", 32'(inst_valid), 32'd0);
        chk("w0_addr", addr2, 32'hFFFF_FFF8);
        tick(); settle();
        chk("f1_addr", imem_addr, 32'h4);
        chk("first_valid", 32'(inst_valid), 32'd1);
        chk("first_pc", inst_pc, 32'h0);
        chk("w1_addr", addr2, 32'hFFFF_FFFC);
        tick(); settle();
        chk("f2_addr", imem_addr, 32'h8);
        chk("w2_addr", addr2, 32'h0);
        chk("w_pc", ipc2, 32'hFFFF_FFFC);
        chk("w_pc4", ipc4_2, 32'h0);

        // Decode stalls with 0x8 in IF/ID while 0xC returns.
        tick(); stall = 1'b1; settle();
        chk("st_pc", inst_pc, 32'h8);
        chk("st_addr", imem_addr, 32'hC);
        tick(); settle();
        chk("hold_req_a", 32'(imem_req), 32'd0);
        tick(); settle();
        chk("hold_req_b", 32'(imem_req), 32'd0);
        chk("hold_pc", inst_pc, 32'h8);
        tick(); stall = 1'b0; settle();
        chk("unstall_pc", inst_pc, 32'h8);

        // Redirect at the 0x10 fetch to an unaligned target.
        tick();
        chk("pre_redir_addr", imem_addr, 32'h10);
        do_redirect(32'h0000_0103);
        settle();
        chk("skid_out_pc", inst_pc, 32'hC);
        tick(); redirect_valid = 1'b0; settle();
        chk("flush_valid", 32'(inst_valid), 32'd0);
        chk("flush_inst", inst, NOP);
        chk("redir_addr", imem_addr, 32'h100);
        tick(); settle();
        chk("redir_valid", 32'(inst_valid), 32'd1);
        chk("redir_pc", inst_pc, 32'h100);

        // Redirect and stall together: flush wins.
        tick(); stall = 1'b1; do_redirect(32'h180); settle();
        tick(); stall = 1'b0; redirect_valid = 1'b0; settle();
        chk("flush_over_stall", 32'(inst_valid), 32'd0);

        // Slow memory: redirect one cycle into the 0x40 request.
        tick(); do_redirect(32'h40); settle();
        fixed_lat = 3;
        tick(); redirect_valid = 1'b0; settle();
        chk("slow_req", 32'(imem_req), 32'd1);
        chk("slow_addr", imem_addr, 32'h40);
        tick(); do_redirect(32'h200); settle();
        chk("drop_addr0", imem_addr, 32'h40);
        got = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick(); redirect_valid = 1'b0; settle();
            chk("drop_req", 32'(imem_req), 32'd1);
            chk("drop_addr", imem_addr, 32'h40);
            if (imem_ack) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) begin
            total++; bad++;
            $display("FAIL drop_ack: no ack within 8 cycles");
        end
        tick(); settle();
        chk("post_drop_req", 32'(imem_req), 32'd1);
        chk("post_drop_addr", imem_addr, 32'h200);

        // Random traffic.
        rand_lat = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            tick();
            stall = ($urandom_range(0, 99) < 30);
            if ($urandom_range(0, 99) < 4) begin
                if ($urandom_range(0, 3) == 0) do_redirect(32'hFFFF_FFF0 | 32'($urandom_range(0, 15)));
                else do_redirect($urandom);
            end else begin
                redirect_valid = 1'b0;
            end
        end
        tick(); stall = 1'b0; redirect_valid = 1'b0; settle();
        rand_lat = 1'b0;

        // Reset in the middle of an outstanding request.
        got = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick(); settle();
            if (imem_req) begin
                got = 1'b1;
                break;
            end
        end
        chk("mid_req_found", 32'(got), 32'd1);
        @(posedge clk); #2; rst = 1'b1;
        restart_stream(32'h0);
        #1;
        chk("mid_rst_req", 32'(imem_req), 32'd0);
        chk("mid_rst_valid", 32'(inst_valid), 32'd0);
        repeat (2) @(negedge clk);
        settle();
        chk("mid_rst_inst", inst, NOP);
        chk("mid_rst_pc", inst_pc, 32'd0);
        @(posedge clk); #2; rst = 1'b0;
        tick(); settle();
        chk("post_rst_idle", 32'(imem_req), 32'd0);
        tick(); settle();
        chk("post_rst_req", 32'(imem_req), 32'd1);
        chk("post_rst_addr", imem_addr, 32'h0);
        rand_lat = 1'b1;
        repeat (40) tick();
        settle();

        chk("progress", 32'(consumed > 500), 32'd1);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
